tile_writeback: RTL

TILE_WRITEBACK -- requirements
Module: tile_writeback

---
 rtl/tile_writeback.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tile_writeback.sv
// Copies a 4x4 tile, one row at a time, from four banked tile memories
// into a row-major global BRAM at a latched base address.
module tile_writeback #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int MATRIX_COLS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] tile_addr,
   output logic                  tile_re,
   input  logic [DATA_WIDTH-1:0] tile_din0,
   input  logic [DATA_WIDTH-1:0] tile_din1,
   input  logic [DATA_WIDTH-1:0] tile_din2,
   input  logic [DATA_WIDTH-1:0] tile_din3,
   output logic [ADDR_WIDTH-1:0] global_addr,
   output logic [DATA_WIDTH-1:0] global_din,
   output logic                  global_we,
   output logic [7:0]            write_count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_CAPTURE,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [1:0]            row_q, row_d;
   logic [1:0]            col_q, col_d;
   logic [DATA_WIDTH-1:0] buf_q [4];
   logic [DATA_WIDTH-1:0] buf_d [4];
   logic [ADDR_WIDTH-1:0] taddr_q, taddr_d;
   logic                  tre_q, tre_d;
   logic [ADDR_WIDTH-1:0] gaddr_q, gaddr_d;
   logic [DATA_WIDTH-1:0] gdin_q, gdin_d;
   logic                  gwe_q, gwe_d;
   logic                  done_q, done_d;
   logic [7:0]            wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-1:0] wr_addr;

   // Truncation to ADDR_WIDTH gives the required modulo wrap.
   assign wr_addr = base_q
                  + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(MATRIX_COLS)
                  + ADDR_WIDTH'(col_q);

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      row_d   = row_q;
      col_d   = col_q;
      buf_d   = buf_q;
      taddr_d = taddr_q;
      tre_d   = 1'b0;
      gaddr_d = gaddr_q;
      gdin_d  = gdin_q;
      gwe_d   = 1'b0;
      done_d  = 1'b0;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               row_d   = 2'd0;
               col_d   = 2'd0;
               wcnt_d  = 8'd0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            taddr_d = ADDR_WIDTH'(row_q);
            tre_d   = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            buf_d[0] = tile_din0;
            buf_d[1] = tile_din1;
            buf_d[2] = tile_din2;
            buf_d[3] = tile_din3;
            col_d    = 2'd0;
            state_d  = ST_WRITE;
         end
         ST_WRITE: begin
            gwe_d   = 1'b1;
            gaddr_d = wr_addr;
            gdin_d  = buf_q[col_q];
            wcnt_d  = wcnt_q + 8'd1;
            col_d   = col_q + 2'd1;
            if (col_q == 2'd3) begin
               if (row_q == 2'd3) begin
                  state_d = ST_DONE;
               end else begin
                  row_d   = row_q + 2'd1;
                  state_d = ST_REQ;
               end
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         for (int i = 0; i < 4; i++) buf_q[i] <= '0;
         taddr_q <= '0;
         tre_q   <= 1'b0;
         gaddr_q <= '0;
         gdin_q  <= '0;
         gwe_q   <= 1'b0;
         done_q  <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         row_q   <= row_d;
         col_q   <= col_d;
         for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
         taddr_q <= taddr_d;
         tre_q   <= tre_d;
         gaddr_q <= gaddr_d;
         gdin_q  <= gdin_d;
         gwe_q   <= gwe_d;
         done_q  <= done_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign tile_addr   = taddr_q;
   assign tile_re     = tre_q;
   assign global_addr = gaddr_q;
   assign global_din  = gdin_q;
   assign global_we   = gwe_q;
   assign write_count = wcnt_q;

endmodule
